axis_deadlock_monitor_param: RTL
================================

Name: axis_deadlock_monitor_param

Overview:
- Parametrised, self-timed deadlock detector for an HLS kernel. It is instantiated inside each kernel's deadlock monitor top.
- Watches N AXI-Stream block flags and M sub-instance idle/block flags. Declares deadlock only after a stall persists for a programmable number of consecutive cycles.
- On detection it latches which streams were blocked, pulses a report strobe, and holds a sticky block flag until cleared.
- Its stall-duration filter, channel capture and clear/re-arm are what the fixed two-stream, instant-trigger monitor lacks.

Parameters:
- NUM_AXIS, 2, number of AXI-Stream block inputs (1..32).
- NUM_INST, 2, number of monitored sub-instances (1..32).
- CNT_W, 16, stall counter width; also the width of the threshold port.
- IDX_W, $clog2(NUM_AXIS) (minimum 1), width of the captured channel index.

Ports:
- kernel_monitor_clock  in  1  sole clock; all state updates on its rising edge.
- kernel_monitor_reset  in  1  synchronous, active-high reset.
- axis_block_sigs  in  NUM_AXIS  1 = stream i is stalled (inverted blk_n).
- inst_idle_sigs  in  NUM_INST  1 = instance j is idle.
- inst_block_sigs  in  NUM_INST  1 = instance j is blocked on a stream or child.
- threshold  in  CNT_W  number of consecutive stall cycles needed to declare deadlock; 0 is treated as 1.
- clear  in  1  re-arms detection; takes effect in any state.
- block  out  1  sticky deadlock flag.
- deadlock_pulse  out  1  one-cycle strobe on entry to DEADLOCK.
- blocked_mask  out  NUM_AXIS  snapshot of axis_block_sigs taken on the detection edge.
- blocked_idx  out  IDX_W  lowest set bit index of blocked_mask.
- stall_cnt  out  CNT_W  current consecutive-stall count, for debug.

Behaviour:
- stall (combinational) = (|axis_block_sigs) && (&(inst_idle_sigs | inst_block_sigs)). In words: at least one stream is blocked and no instance is making progress.
- thr_eff = (threshold == 0) ? 1 : threshold.
- Reset: state = IDLE; block, deadlock_pulse, blocked_mask, blocked_idx and stall_cnt are all 0.
- FSM states: IDLE, WATCH, DEADLOCK.
- IDLE
  - !stall: stay in IDLE, cnt = 0.
  - stall and thr_eff == 1: go to DEADLOCK.
  - stall otherwise: go to WATCH, cnt = 1.
- WATCH
  - !stall: go to IDLE, cnt = 0. Any single progress cycle restarts the count.
  - stall and cnt+1 >= thr_eff: go to DEADLOCK.
  - stall otherwise: cnt = cnt+1.
  - The comparison uses >= so that lowering threshold mid-count triggers on the next stall cycle.
- Detection timing: block is 1 in the cycle after the T-th consecutive cycle in which stall is sampled high (T = thr_eff).
- Entry into DEADLOCK, same edge for all of the following:
  - block <= 1.
  - deadlock_pulse <= 1 for exactly one cycle.
  - blocked_mask <= axis_block_sigs.
  - blocked_idx <= priority encode of that mask, lowest index wins.
  - stall_cnt holds its value; it is not cleared.
- DEADLOCK
  - Outputs are frozen regardless of stall.
  - Leaves only on clear or reset.
- clear (all states): the next state is IDLE and every output returns to its reset value, including when clear and stall are both high in the same cycle.
  - Clear has priority over all transitions, including a detection in the same cycle.
  - After clear, detection restarts from cnt = 0.
- Counter: stall_cnt saturates at 2^CNT_W-1 and never wraps. With thr_eff at its maximum, detection still occurs through the >= comparison.
- Reset asserted mid-WATCH or in DEADLOCK: outputs return to reset values at the next edge. Reset has priority over clear.
- Latency: exactly one register stage from inputs to outputs. There are no combinational paths from inputs to outputs.

Decomposition:
- Package axis_deadlock_pkg holds:
  - the FSM state enum (2-bit: IDLE = 0, WATCH = 1, DEADLOCK = 2);
  - the THR_MIN = 1 constant;
  - a function lowest_set_idx(mask) used for blocked_idx.
- One sub-module is natural: deadlock_stall_counter. It is the saturating CNT_W counter with clear/inc/compare, and outputs reached = (cnt+1 >= thr_eff).
- The FSM and the capture registers stay in the top.

Test Plan:
- Threshold 4; stall held 3 cycles, then one cycle where inst_idle_sigs = inst_block_sigs = 0 with axis still blocked, then stall again -> block stays 0 and stall_cnt returns to 0. Holding stall 4 more cycles gives block = 1 on the following cycle.
- NUM_AXIS = 4, threshold 8, axis_block_sigs = 4'b1010 throughout the stall -> blocked_mask = 1010, blocked_idx = 1, deadlock_pulse high exactly 1 cycle, block stays 1 for 20 further cycles.
- threshold = 0 with stall in a single cycle -> block = 1 on the next edge, behaving the same as threshold = 1.
- In DEADLOCK, assert clear together with stall for 1 cycle -> next cycle block = 0 and mask = 0. With stall held and threshold 3, block re-asserts 3 cycles after clear deasserts.
- WATCH at stall_cnt = 10 with threshold 100, then threshold lowered to 5 while stall is held -> DEADLOCK entered on the next edge.
- Reset pulsed for 1 cycle while in DEADLOCK -> all outputs 0 on the next edge; no deadlock_pulse until a fresh full-threshold stall.

Source files
------------

// File: rtl/axis_deadlock_pkg.sv
`default_nettype none
// ============================================================================
// Module      : axis_deadlock_pkg
// Description : Shared types, constants and helpers for the parametrised
//               AXI-Stream deadlock monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package axis_deadlock_pkg;

    // Monitor FSM encoding
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WATCH    = 2'd1,
        ST_DEADLOCK = 2'd2
    } state_e;

    // A programmed threshold of zero is promoted to this value
    localparam int THR_MIN = 1;

    // Index of the lowest set bit; returns 0 for an all-zero mask
    function automatic logic [4:0] lowest_set_idx(input logic [31:0] mask);
        logic [4:0] idx;
        idx = '0;
        for (int i = 31; i >= 0; i--) begin
            if (mask[i]) begin
                idx = 5'(i);
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/axis_deadlock_monitor_param_stall_counter.sv
`default_nettype none
// ============================================================================
// Module      : deadlock_stall_counter
// Description : Saturating consecutive-stall counter with synchronous clear,
//               increment and a "next count reaches threshold" compare.
// Revision    : 1.0 - initial release
// ============================================================================
module deadlock_stall_counter
    import axis_deadlock_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr_i,
    input  logic             inc_i,
    input  logic [CNT_W-1:0] thr_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             reached_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic [CNT_W-1:0] thr_eff;
    logic [CNT_W:0]   cnt_nxt;

    // Zero threshold behaves exactly like a threshold of one
    always_comb thr_eff = (thr_i == '0) ? CNT_W'(THR_MIN) : thr_i;

    // One extra bit so the compare stays correct when cnt_q is saturated
    always_comb cnt_nxt = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

    assign reached_o = (cnt_nxt >= {1'b0, thr_eff});
    assign cnt_o     = cnt_q;

    // Clear wins over increment; increment stops at all-ones instead of wrapping
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_nxt[CNT_W-1:0];
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/axis_deadlock_monitor_param.sv
`default_nettype none
// ============================================================================
// Module      : axis_deadlock_monitor_param
// Description : Self-timed deadlock detector. Declares deadlock after a
//               programmable run of consecutive stall cycles, captures the
//               blocked streams and holds a sticky flag until cleared.
// Revision    : 1.0 - initial release
// ============================================================================
module axis_deadlock_monitor_param
    import axis_deadlock_pkg::*;
#(
    parameter int NUM_AXIS = 2,
    parameter int NUM_INST = 2,
    parameter int CNT_W    = 16,
    parameter int IDX_W    = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1
) (
    input  logic                kernel_monitor_clock,
    input  logic                kernel_monitor_reset,
    input  logic [NUM_AXIS-1:0] axis_block_sigs,
    input  logic [NUM_INST-1:0] inst_idle_sigs,
    input  logic [NUM_INST-1:0] inst_block_sigs,
    input  logic [CNT_W-1:0]    threshold,
    input  logic                clear,
    output logic                block,
    output logic                deadlock_pulse,
    output logic [NUM_AXIS-1:0] blocked_mask,
    output logic [IDX_W-1:0]    blocked_idx,
    output logic [CNT_W-1:0]    stall_cnt
);

    state_e              state_q;
    state_e              state_d;
    logic                stall;
    logic                reached;
    logic                detect;
    logic                cnt_clr;
    logic                cnt_inc;
    logic                block_q;
    logic                block_d;
    logic                pulse_q;
    logic                pulse_d;
    logic [NUM_AXIS-1:0] mask_q;
    logic [NUM_AXIS-1:0] mask_d;
    logic [IDX_W-1:0]    idx_q;
    logic [IDX_W-1:0]    idx_d;

    // A stream is stuck and no instance is making forward progress
    always_comb stall = (|axis_block_sigs) && (&(inst_idle_sigs | inst_block_sigs));

    deadlock_stall_counter #(
        .CNT_W (CNT_W)
    ) u_stall_counter (
        .clk       (kernel_monitor_clock),
        .rst       (kernel_monitor_reset),
        .clr_i     (cnt_clr),
        .inc_i     (cnt_inc),
        .thr_i     (threshold),
        .cnt_o     (stall_cnt),
        .reached_o (reached)
    );

    // State register
    always_ff @(posedge kernel_monitor_clock) begin
        if (kernel_monitor_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: clear re-arms from anywhere, DEADLOCK is otherwise absorbing
    always_comb begin
        state_d = state_q;
        if (clear) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE, ST_WATCH: begin
                    if (!stall) begin
                        state_d = ST_IDLE;
                    end else if (reached) begin
                        state_d = ST_DEADLOCK;
                    end else begin
                        state_d = ST_WATCH;
                    end
                end
                ST_DEADLOCK: state_d = ST_DEADLOCK;
                default:     state_d = ST_IDLE;
            endcase
        end
    end

    // Output/next-capture logic: snapshot on the detection edge, freeze after
    always_comb begin
        detect  = !clear && stall && reached && (state_q != ST_DEADLOCK);
        cnt_clr = clear || ((state_q != ST_DEADLOCK) && !stall);
        cnt_inc = (state_q != ST_DEADLOCK) && stall && !reached;
        block_d = block_q;
        pulse_d = 1'b0;
        mask_d  = mask_q;
        idx_d   = idx_q;
        if (clear) begin
            block_d = 1'b0;
            mask_d  = '0;
            idx_d   = '0;
        end else if (detect) begin
            block_d = 1'b1;
            pulse_d = 1'b1;
            mask_d  = axis_block_sigs;
            idx_d   = IDX_W'(lowest_set_idx(32'(axis_block_sigs)));
        end
    end

    // Capture registers driving the outputs directly
    always_ff @(posedge kernel_monitor_clock) begin
        if (kernel_monitor_reset) begin
            block_q <= 1'b0;
            pulse_q <= 1'b0;
            mask_q  <= '0;
            idx_q   <= '0;
        end else begin
            block_q <= block_d;
            pulse_q <= pulse_d;
            mask_q  <= mask_d;
            idx_q   <= idx_d;
        end
    end

    assign block          = block_q;
    assign deadlock_pulse = pulse_q;
    assign blocked_mask   = mask_q;
    assign blocked_idx    = idx_q;

endmodule
`default_nettype wire
